puzzle_checker: RTL and testbench
=================================

# puzzle_checker

Synchronous stimulus-and-scoring harness that drives a Turing Tumble puzzle top level from the far side of its `start`/`stopped`/`colour` interface. It launches a run, brings the asynchronous `stopped` and `colour` outputs into the clock domain, records the colour-change history and elapsed cycles, and scores the run against expected values. It sits between the puzzle instance and the FPGA or bench control logic, one checker per puzzle instance.

## Interface
Parameters:
- START_LEN, 4: cycles `puzzle_start` is held high (1..255).
- TIMEOUT, 50000: cycles allowed in WAIT before aborting (1..65535).
- SETTLE, 8: consecutive cycles synced `stopped` must read 1 before the run is accepted.
- HIST_DEPTH, 16: colour-history register width (1..32).
- EXP_COLOUR, 0: expected final colour (0 = blue, 1 = red).
- EXP_TOGGLES, 0: expected colour-change count.
- EXP_HIST, 0: expected history value, HIST_DEPTH bits.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- go  in  1  run request; sampled only in IDLE and DONE.
- puzzle_start  out  1  drives the puzzle `start` input.
- puzzle_stopped  in  1  puzzle `stopped`; asynchronous.
- puzzle_colour  in  1  puzzle `colour`; asynchronous.
- busy  out  1  high in ARM, WAIT and SETTLE.
- done  out  1  high in DONE; results are valid.
- pass  out  1  valid with `done`.
- timed_out  out  1  valid with `done`.
- stuck  out  1  `stopped` was already high at launch; valid with `done`.
- colour_final  out  1  synced colour captured on SETTLE exit.
- toggles  out  8  colour-change count; saturates at 255.
- history  out  HIST_DEPTH  colour values after each change; newest value in bit 0.
- cycles  out  16  cycles spent in WAIT plus SETTLE; saturates at 65535.

## Operation
- Synchronisers: `puzzle_stopped` and `puzzle_colour` each pass through a 2-FF synchroniser; all logic uses the synced values (`s_stop`, `s_col`). Colour-change event: `s_col` differs from its one-cycle-delayed copy.
- State machine:
  - IDLE → ARM on `go`. The transition clears `toggles`, `history`, `cycles`, `stuck` and `timed_out`, and loads the history LSB with the current `s_col`.
  - ARM: `puzzle_start` = 1 for exactly START_LEN cycles. If `s_stop` = 1 on the first ARM cycle, set `stuck` and go to DONE after ARM completes. Otherwise go to WAIT.
  - WAIT: `cycles` increments each cycle. When `s_stop` = 1, go to SETTLE with the settle counter at 1. When `cycles` reaches TIMEOUT, set `timed_out` and go to DONE.
  - SETTLE: `cycles` keeps counting. If `s_stop` = 0, return to WAIT. When `s_stop` has been 1 for SETTLE cycles, capture `colour_final` = `s_col` and go to DONE.
  - DONE: results are held. `go` starts a new run (DONE → ARM, same clearing as IDLE → ARM).
- Colour changes during ARM, WAIT and SETTLE:
  - increment `toggles`, saturating at 255;
  - shift `history` left by one with `s_col` entering bit 0; bits shifted out are lost.
  - Colour changes are ignored in IDLE and DONE.
- Scoring: `pass` = !`stuck` & !`timed_out` & (`colour_final` == EXP_COLOUR) & (`toggles` == EXP_TOGGLES) & (`history` == EXP_HIST). Computed and registered on entry to DONE.
- `go` is ignored while `busy`.

## Timing
- Reset values: state IDLE; `puzzle_start`, `busy`, `done`, `pass`, `timed_out`, `stuck`, `colour_final` all 0; `toggles`, `history`, `cycles` all 0; synchronisers 0.
- `go` high at edge N:
  - `puzzle_start` and `busy` are high from N+1 through N+START_LEN;
  - WAIT starts at N+START_LEN+1.
- Input-to-logic latency is 2 cycles (synchroniser). A colour change is counted 3 cycles after the pin changes.
- A SETTLE that completes without interruption lasts SETTLE cycles. `done` rises on the following edge.
- Timeout and settle completion in the same cycle: timeout wins, and `timed_out` = 1.
- A `s_stop` glitch shorter than SETTLE cycles costs time but does not change the outcome, apart from `cycles`.
- `rst` asserted mid-run: the next edge returns the block to IDLE and `puzzle_start` = 0 on that edge. The puzzle itself is not reset by this block.
- `go` held high continuously: runs repeat back to back. DONE lasts one cycle per run.

## Test plan
- Reset then idle, no `go` → all outputs 0, `puzzle_start` never asserted.
- Defaults, `go` 1 cycle; model `stopped` rises 100 cycles after `start` falls, `colour` stays 0 → `puzzle_start` high 4 cycles; `done` = 1, `pass` = 1, `toggles` = 0, `cycles` = 100 + 2 sync + 8 settle.
- EXP_TOGGLES = 3, EXP_HIST = 0b0101, EXP_COLOUR = 1; colour toggles 0→1→0→1, then stop → `toggles` = 3, `history` = 0x5, `colour_final` = 1, `pass` = 1. Rerun with 4 toggles → `pass` = 0.
- TIMEOUT = 200, `stopped` never rises → `done` at WAIT + 200, `timed_out` = 1, `pass` = 0, `cycles` = 200.
- `stopped` tied high before `go` → `stuck` = 1, `pass` = 0, `done` after 4 ARM cycles. Separately: a 3-cycle `stopped` pulse with SETTLE = 8, then a real stop → `done` only after the real stop.
- `rst` pulsed in the 2nd ARM cycle → `puzzle_start` = 0 next edge, state IDLE. `go` held high for 3 runs → `done` pulses 3 times, `toggles` cleared on each run.

Source files
------------

// File: rtl/puzzle_checker.sv
// Scoring harness for one Turing Tumble puzzle instance. It launches a run, times it, records
// the colour-change history and compares the outcome with the expected values.
module puzzle_checker #(
  parameter int unsigned           START_LEN   = 4,
  parameter int unsigned           TIMEOUT     = 50000,
  parameter int unsigned           SETTLE      = 8,
  parameter int unsigned           HIST_DEPTH  = 16,
  parameter bit                    EXP_COLOUR  = 1'b0,
  parameter int unsigned           EXP_TOGGLES = 0,
  parameter logic [HIST_DEPTH-1:0] EXP_HIST    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  output logic                  puzzle_start,
  input  logic                  puzzle_stopped,
  input  logic                  puzzle_colour,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic                  stuck,
  output logic                  colour_final,
  output logic [7:0]            toggles,
  output logic [HIST_DEPTH-1:0] history,
  output logic [15:0]           cycles
);

  typedef enum logic [2:0] {StIdle, StArm, StWait, StSettle, StDone} state_e;

  state_e                state_q, state_d;
  logic [7:0]            arm_q, arm_d;
  logic [15:0]           settle_q, settle_d;
  logic                  start_q, start_d;
  logic                  pass_q, pass_d;
  logic                  timed_out_q, timed_out_d;
  logic                  stuck_q, stuck_d;
  logic                  colour_final_q, colour_final_d;
  logic [7:0]            toggles_q, toggles_d;
  logic [HIST_DEPTH-1:0] history_q, history_d;
  logic [15:0]           cycles_q, cycles_d;
  logic                  stop_meta_q, stop_sync_q;
  logic                  col_meta_q, col_sync_q, col_prev_q;

  logic                  running;
  logic                  timeout_hit;
  logic [15:0]           cycles_inc;
  logic [HIST_DEPTH-1:0] col_vec;

  assign running = (state_q == StArm) || (state_q == StWait) || (state_q == StSettle);

  always_comb begin
    state_d        = state_q;
    arm_d          = arm_q;
    settle_d       = settle_q;
    pass_d         = pass_q;
    timed_out_d    = timed_out_q;
    stuck_d        = stuck_q;
    colour_final_d = colour_final_q;
    toggles_d      = toggles_q;
    history_d      = history_q;
    cycles_d       = cycles_q;
    col_vec        = '0;
    col_vec[0]     = col_sync_q;
    cycles_inc     = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;
    timeout_hit    = (32'(cycles_q) + 32'd1) >= TIMEOUT;

    case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d     = StArm;
          arm_d       = '0;
          toggles_d   = '0;
          history_d   = col_vec;
          cycles_d    = '0;
          stuck_d     = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      StArm: begin
        if (arm_q == 8'd0 && stop_sync_q) stuck_d = 1'b1;
        if (arm_q == 8'(START_LEN - 1)) begin
          state_d = stuck_d ? StDone : StWait;
        end else begin
          arm_d = arm_q + 8'd1;
        end
      end
      StWait: begin
        cycles_d = cycles_inc;
        if (timeout_hit) begin
          timed_out_d = 1'b1;
          state_d     = StDone;
        end else if (stop_sync_q) begin
          // The cycle that first sees stopped counts as the first settle cycle.
          if (SETTLE <= 1) begin
            colour_final_d = col_sync_q;
            state_d        = StDone;
          end else begin
            settle_d = 16'd1;
            state_d  = StSettle;
          end
        end
      end
      StSettle: begin
        cycles_d = cycles_inc;
        if (timeout_hit) begin
          timed_out_d = 1'b1;
          state_d     = StDone;
        end else if (!stop_sync_q) begin
          state_d = StWait;
        end else if ((32'(settle_q) + 32'd1) >= SETTLE) begin
          colour_final_d = col_sync_q;
          state_d        = StDone;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (running && (col_sync_q != col_prev_q)) begin
      if (toggles_q != 8'hFF) toggles_d = toggles_q + 8'd1;
      history_d = (history_q << 1) | col_vec;
    end

    // Score with the values that will be held throughout DONE.
    if (state_d == StDone && state_q != StDone) begin
      pass_d = !stuck_d && !timed_out_d && (colour_final_d == EXP_COLOUR) &&
               (32'(toggles_d) == EXP_TOGGLES) && (history_d == EXP_HIST);
    end

    start_d = (state_d == StArm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      arm_q          <= '0;
      settle_q       <= '0;
      start_q        <= 1'b0;
      pass_q         <= 1'b0;
      timed_out_q    <= 1'b0;
      stuck_q        <= 1'b0;
      colour_final_q <= 1'b0;
      toggles_q      <= '0;
      history_q      <= '0;
      cycles_q       <= '0;
      stop_meta_q    <= 1'b0;
      stop_sync_q    <= 1'b0;
      col_meta_q     <= 1'b0;
      col_sync_q     <= 1'b0;
      col_prev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      arm_q          <= arm_d;
      settle_q       <= settle_d;
      start_q        <= start_d;
      pass_q         <= pass_d;
      timed_out_q    <= timed_out_d;
      stuck_q        <= stuck_d;
      colour_final_q <= colour_final_d;
      toggles_q      <= toggles_d;
      history_q      <= history_d;
      cycles_q       <= cycles_d;
      stop_meta_q    <= puzzle_stopped;
      stop_sync_q    <= stop_meta_q;
      col_meta_q     <= puzzle_colour;
      col_sync_q     <= col_meta_q;
      col_prev_q     <= col_sync_q;
    end
  end

  assign puzzle_start = start_q;
  assign busy         = running;
  assign done         = (state_q == StDone);
  assign pass         = pass_q;
  assign timed_out    = timed_out_q;
  assign stuck        = stuck_q;
  assign colour_final = colour_final_q;
  assign toggles      = toggles_q;
  assign history      = history_q;
  assign cycles       = cycles_q;

endmodule

// File: tb/tb_puzzle_checker.sv
// Self-checking bench for puzzle_checker: two instances with different expected values share the
// stimulus and are compared every cycle against a behavioural run model.
module tb_puzzle_checker;

  localparam int unsigned START_LEN = 4;
  localparam int unsigned TIMEOUT   = 200;
  localparam int unsigned SETTLE    = 8;
  localparam int PH_IDLE = 0, PH_ARM = 1, PH_WAIT = 2, PH_SETTLE = 3, PH_DONE = 4;

  logic clk = 1'b0;
  logic rst, go, stopped, colour;

  logic o0_start, o0_busy, o0_done, o0_pass, o0_to, o0_stuck, o0_cf;
  logic [7:0] o0_tog;
  logic [15:0] o0_hist, o0_cyc;
  logic o1_start, o1_busy, o1_done, o1_pass, o1_to, o1_stuck, o1_cf;
  logic [7:0] o1_tog;
  logic [15:0] o1_hist, o1_cyc;

  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  puzzle_checker #(
    .START_LEN(START_LEN), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE), .HIST_DEPTH(16)
  ) u_dut0 (
    .clk(clk), .rst(rst), .go(go), .puzzle_start(o0_start), .puzzle_stopped(stopped),
    .puzzle_colour(colour), .busy(o0_busy), .done(o0_done), .pass(o0_pass),
    .timed_out(o0_to), .stuck(o0_stuck), .colour_final(o0_cf), .toggles(o0_tog),
    .history(o0_hist), .cycles(o0_cyc)
  );

  puzzle_checker #(
    .START_LEN(START_LEN), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE), .HIST_DEPTH(16),
    .EXP_COLOUR(1'b1), .EXP_TOGGLES(3), .EXP_HIST(16'h0005)
  ) u_dut1 (
    .clk(clk), .rst(rst), .go(go), .puzzle_start(o1_start), .puzzle_stopped(stopped),
    .puzzle_colour(colour), .busy(o1_busy), .done(o1_done), .pass(o1_pass),
    .timed_out(o1_to), .stuck(o1_stuck), .colour_final(o1_cf), .toggles(o1_tog),
    .history(o1_hist), .cycles(o1_cyc)
  );

  // Behavioural model: a run is a sequence of phases; stop is judged by the length of the
  // current run of synced-high samples, pins reach the logic two edges late.
  int m_phase, m_arm_left, m_run, m_toggles, m_cycles, m_was;
  logic [31:0] m_hist;
  bit m_stuck, m_to, m_cf, m_pass0, m_pass1, m_start, m_sstop, m_scol;
  bit ps [1:3];
  bit pc [1:3];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = PH_IDLE; m_arm_left = 0; m_run = 0; m_toggles = 0; m_cycles = 0;
      m_hist = 0; m_stuck = 0; m_to = 0; m_cf = 0; m_pass0 = 0; m_pass1 = 0;
      for (int k = 1; k <= 3; k++) begin ps[k] = 0; pc[k] = 0; end
    end else begin
      m_sstop = ps[2];
      m_scol  = pc[2];
      m_was   = m_phase;
      if ((m_was == PH_ARM || m_was == PH_WAIT || m_was == PH_SETTLE) && pc[2] != pc[3]) begin
        if (m_toggles < 255) m_toggles++;
        m_hist = ((m_hist << 1) | 32'(m_scol)) & 32'h0000_FFFF;
      end
      if (m_was == PH_IDLE || m_was == PH_DONE) begin
        if (go) begin
          m_phase = PH_ARM; m_arm_left = START_LEN; m_toggles = 0; m_hist = 32'(m_scol);
          m_cycles = 0; m_stuck = 0; m_to = 0;
        end
      end else if (m_was == PH_ARM) begin
        if (m_arm_left == START_LEN && m_sstop) m_stuck = 1;
        m_arm_left--;
        if (m_arm_left == 0) begin
          m_phase = m_stuck ? PH_DONE : PH_WAIT;
          m_run = 0;
        end
      end else begin
        if (m_cycles < 65535) m_cycles++;
        m_run = m_sstop ? m_run + 1 : 0;
        if (m_cycles >= TIMEOUT) begin
          m_to = 1; m_phase = PH_DONE;
        end else if (m_run >= SETTLE) begin
          m_cf = m_scol; m_phase = PH_DONE;
        end else begin
          m_phase = (m_run > 0) ? PH_SETTLE : PH_WAIT;
        end
      end
      if (m_phase == PH_DONE && m_was != PH_DONE) begin
        m_pass0 = !m_stuck && !m_to && m_cf == 0 && m_toggles == 0 && m_hist == 0;
        m_pass1 = !m_stuck && !m_to && m_cf == 1 && m_toggles == 3 && m_hist == 5;
      end
      ps[3] = ps[2]; ps[2] = ps[1]; ps[1] = stopped;
      pc[3] = pc[2]; pc[2] = pc[1]; pc[1] = colour;
    end
    m_start = (m_phase == PH_ARM);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_dut(input string p, input logic st, input logic bz, input logic dn,
                         input logic pa, input logic to, input logic sk, input logic cf,
                         input logic [7:0] tg, input logic [15:0] hs, input logic [15:0] cy,
                         input bit exp_pass);
    check({p, " puzzle_start"}, 32'(st), 32'(m_start));
    check({p, " busy"}, 32'(bz),
          32'(m_phase == PH_ARM || m_phase == PH_WAIT || m_phase == PH_SETTLE));
    check({p, " done"}, 32'(dn), 32'(m_phase == PH_DONE));
    check({p, " pass"}, 32'(pa), 32'(exp_pass));
    check({p, " timed_out"}, 32'(to), 32'(m_to));
    check({p, " stuck"}, 32'(sk), 32'(m_stuck));
    check({p, " colour_final"}, 32'(cf), 32'(m_cf));
    check({p, " toggles"}, 32'(tg), 32'(m_toggles));
    check({p, " history"}, 32'(hs), m_hist);
    check({p, " cycles"}, 32'(cy), 32'(m_cycles));
  endtask

  always @(negedge clk) begin
    if (o0_start === 1'b1) start_cnt++;
    if (chk_en) begin
      cmp_dut("dut0", o0_start, o0_busy, o0_done, o0_pass, o0_to, o0_stuck, o0_cf, o0_tog,
              o0_hist, o0_cyc, m_pass0);
      cmp_dut("dut1", o1_start, o1_busy, o1_done, o1_pass, o1_to, o1_stuck, o1_cf, o1_tog,
              o1_hist, o1_cyc, m_pass1);
    end
  end

  task automatic launch();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_start_low();
    bit ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o0_start === 1'b0) begin ok = 1'b1; break; end
    end
    check("start falls in bound", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o0_done === 1'b1) begin ok = 1'b1; break; end
    end
    check("done reached in bound", 32'(ok), 32'd1);
  endtask

  task automatic settle_pins();
    stopped = 1'b0;
    colour  = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual running, required finished");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst = 1'b1; go = 1'b0; stopped = 1'b0; colour = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing launches.
    repeat (20) @(negedge clk);
    check("idle start count", 32'(start_cnt), 32'd0);
    check("idle cycles", 32'(o0_cyc), 32'd0);
    check("idle done", 32'(o0_done), 32'd0);

    // Clean run: stop 100 cycles after start falls, colour steady at 0.
    start_cnt = 0;
    launch();
    wait_start_low();
    repeat (100) @(negedge clk);
    stopped = 1'b1;
    wait_done(40);
    check("clean start count", 32'(start_cnt), 32'd4);
    check("clean cycles", 32'(o0_cyc), 32'd110);
    check("clean model cycles", 32'(m_cycles), 32'd110);
    check("clean pass", 32'(o0_pass), 32'd1);
    check("clean toggles", 32'(o0_tog), 32'd0);
    settle_pins();

    // Three colour changes ending on red: dut1 expects exactly this.
    launch();
    wait_start_low();
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(negedge clk);
      colour = ~colour;
    end
    repeat (10) @(negedge clk);
    stopped = 1'b1;
    wait_done(40);
    check("3-toggle pass dut1", 32'(o1_pass), 32'd1);
    check("3-toggle pass dut0", 32'(o0_pass), 32'd0);
    check("3-toggle toggles", 32'(o1_tog), 32'd3);
    check("3-toggle history", 32'(o1_hist), 32'h5);
    check("3-toggle model history", m_hist, 32'h5);
    check("3-toggle colour_final", 32'(o1_cf), 32'd1);
    stopped = 1'b0;
    repeat (6) @(negedge clk);

    // Four changes starting from red: history 1,0,1,0,1.
    launch();
    wait_start_low();
    for (int i = 0; i < 4; i++) begin
      repeat (10) @(negedge clk);
      colour = ~colour;
    end
    repeat (10) @(negedge clk);
    stopped = 1'b1;
    wait_done(40);
    check("4-toggle pass dut1", 32'(o1_pass), 32'd0);
    check("4-toggle toggles", 32'(o1_tog), 32'd4);
    check("4-toggle history", 32'(o1_hist), 32'h15);
    settle_pins();

    // Timeout: stopped never rises.
    launch();
    wait_done(260);
    check("timeout flag", 32'(o0_to), 32'd1);
    check("timeout cycles", 32'(o0_cyc), 32'd200);
    check("timeout pass", 32'(o0_pass), 32'd0);

    // Stopped already high at launch.
    stopped = 1'b1;
    repeat (5) @(negedge clk);
    launch();
    repeat (3) @(negedge clk);
    check("stuck done early", 32'(o0_done), 32'd0);
    @(negedge clk);
    check("stuck done after arm", 32'(o0_done), 32'd1);
    check("stuck flag", 32'(o0_stuck), 32'd1);
    check("stuck pass", 32'(o0_pass), 32'd0);
    settle_pins();

    // Short stopped glitch must not end the run.
    launch();
    wait_start_low();
    repeat (30) @(negedge clk);
    stopped = 1'b1;
    repeat (3) @(negedge clk);
    stopped = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch no early done", 32'(o0_done), 32'd0);
    stopped = 1'b1;
    wait_done(40);
    check("glitch pass", 32'(o0_pass), 32'd1);
    settle_pins();

    // Reset during the second ARM cycle.
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset start low", 32'(o0_start), 32'd0);
    check("reset busy low", 32'(o0_busy), 32'd0);
    repeat (4) @(negedge clk);

    // go held high: back-to-back (stuck) runs with colour activity.
    stopped = 1'b1;
    repeat (5) @(negedge clk);
    go = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      colour = ~colour;
      if (o0_done === 1'b1) pulses++;
      if (pulses == 3) break;
    end
    go = 1'b0;
    check("held go done pulses", 32'(pulses), 32'd3);
    settle_pins();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      go = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) colour = ~colour;
      if ($urandom_range(0, 39) == 0) stopped = ~stopped;
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    go = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
